// File: rtl/rns_mod_arbiter_if.sv
// Request, reducer and response bundle for rns_mod_arbiter.
// The arbiter uses the slave view; requesters, the reducer and the response consumer use the master view.
interface rns_mod_arbiter_if #(
   parameter int NREQ = 4,
   parameter int DW   = 32,
   parameter int RW   = 7,
   parameter int IDW  = $clog2(NREQ)
);
   logic [NREQ-1:0]    req_valid;
   logic [NREQ*DW-1:0] req_data;
   logic [NREQ-1:0]    req_ready;
   logic [DW-1:0]      red_operand;
   logic [RW-1:0]      red_result;
   logic               resp_valid;
   logic               resp_ready;
   logic [IDW-1:0]     resp_id;
   logic [RW-1:0]      resp_data;
   logic               busy;
   logic               err;

   modport master (
      output req_valid, req_data, red_result, resp_ready,
      input  req_ready, red_operand, resp_valid, resp_id, resp_data, busy, err
   );

   modport slave (
      input  req_valid, req_data, red_result, resp_ready,
      output req_ready, red_operand, resp_valid, resp_id, resp_data, busy, err
   );
endinterface

// File: rtl/rns_mod_arbiter.sv
// Round-robin sharing of one combinational mod-MOD reducer among NREQ requesters.
// A request is granted in IDLE, reduced in EVAL and returned with its requester id in RESP.
module rns_mod_arbiter #(
   parameter int NREQ = 4,
   parameter int DW   = 32,
   parameter int RW   = 7,
   parameter int MOD  = 21,
   parameter int IDW  = $clog2(NREQ)
) (
   input logic              clk,
   input logic              rst,
   rns_mod_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, EVAL, RESP} state_t;

   state_t          state;
   logic [IDW-1:0]  rr_ptr;
   logic [IDW-1:0]  id_reg;
   logic [DW-1:0]   op_reg;
   logic            rst_hold;
   logic            resp_valid;
   logic [IDW-1:0]  resp_id;
   logic [RW-1:0]   resp_data;
   logic            busy;
   logic            err;

   logic            grant_found;
   logic [IDW-1:0]  grant_id;
   logic [NREQ-1:0] grant_vec;
   logic            accept;

   // First valid requester found scanning upward from rr_ptr, wrapping at NREQ.
   always_comb begin : grant_scan
      int idx;
      idx         = 0;
      grant_found = 1'b0;
      grant_id    = '0;
      grant_vec   = '0;
      for (int k = 0; k < NREQ; k++) begin
         idx = (int'(rr_ptr) + k) % NREQ;
         if (!grant_found && bus.req_valid[idx]) begin
            grant_found = 1'b1;
            grant_id    = IDW'(idx);
         end
      end
      if (grant_found) begin
         grant_vec[grant_id] = 1'b1;
      end
   end

   // rst_hold keeps the grant closed for the first cycle after reset is released.
   assign accept        = (state == IDLE) && !rst && !rst_hold && grant_found;
   assign bus.req_ready = accept ? grant_vec : '0;

   assign bus.red_operand = op_reg;
   assign bus.resp_valid  = resp_valid;
   assign bus.resp_id     = resp_id;
   assign bus.resp_data   = resp_data;
   assign bus.busy        = busy;
   assign bus.err         = err;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         rr_ptr     <= '0;
         id_reg     <= '0;
         op_reg     <= '0;
         rst_hold   <= 1'b1;
         resp_valid <= 1'b0;
         resp_id    <= '0;
         resp_data  <= '0;
         busy       <= 1'b0;
         err        <= 1'b0;
      end else begin
         rst_hold <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  op_reg <= bus.req_data[int'(grant_id)*DW +: DW];
                  id_reg <= grant_id;
                  busy   <= 1'b1;
                  state  <= EVAL;
               end
            end
            EVAL: begin
               // An out-of-range residue is still delivered; err only flags it.
               resp_data  <= bus.red_result;
               resp_id    <= id_reg;
               resp_valid <= 1'b1;
               if (int'(bus.red_result) >= MOD) begin
                  err <= 1'b1;
               end
               state <= RESP;
            end
            RESP: begin
               if (bus.resp_ready) begin
                  resp_valid <= 1'b0;
                  busy       <= 1'b0;
                  rr_ptr     <= (int'(id_reg) == NREQ - 1) ? '0 : id_reg + 1'b1;
                  state      <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_rns_mod_arbiter.sv
// Directed and randomized bench for rns_mod_arbiter against a transaction-level round-robin model.
module tb_rns_mod_arbiter;
   localparam int NREQ = 4;
   localparam int DW   = 32;
   localparam int RW   = 7;
   localparam int MOD  = 21;
   localparam int IDW  = 2;

   logic clk = 1'b0;
   logic rst;
   logic force_bad;
   int   checks   = 0;
   int   failures = 0;

   bit             active [NREQ];
   logic [DW-1:0]  opnd   [NREQ];
   int             ptr;
   bit             err_exp;
   int             retire_mode;
   logic [IDW-1:0] last_id;
   logic [RW-1:0]  last_data;

   int t2_id  [4] = '{0, 1, 2, 3};
   int t2_res [4] = '{0, 1, 1, 15};
   int t4_id  [6] = '{0, 2, 0, 2, 0, 2};

   always #5 clk = ~clk;

   rns_mod_arbiter_if #(.NREQ(NREQ), .DW(DW), .RW(RW), .IDW(IDW)) bus ();

   rns_mod_arbiter #(.NREQ(NREQ), .DW(DW), .RW(RW), .MOD(MOD), .IDW(IDW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Stand-in for the shared reducer, with an override to inject an out-of-range residue.
   assign bus.red_result = force_bad ? RW'(25) : RW'(bus.red_operand % MOD);

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic int exp_grant();
      for (int k = 0; k < NREQ; k++) begin
         if (active[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
      end
      return -1;
   endfunction

   task automatic drive_reqs();
      for (int i = 0; i < NREQ; i++) begin
         bus.req_valid[i]           = active[i];
         bus.req_data[i*DW +: DW]   = opnd[i];
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, ".req_ready"},   bus.req_ready,   0);
      check({tag, ".resp_valid"},  bus.resp_valid,  0);
      check({tag, ".resp_id"},     bus.resp_id,     0);
      check({tag, ".resp_data"},   bus.resp_data,   0);
      check({tag, ".busy"},        bus.busy,        0);
      check({tag, ".err"},         bus.err,         0);
      check({tag, ".red_operand"}, bus.red_operand, 0);
   endtask

   // Called in the low phase; returns in the low phase one cycle after reset is released.
   task automatic do_reset(input string tag);
      rst = 1'b1;
      @(negedge clk);
      #1;
      check_reset_outputs(tag);
      rst = 1'b0;
      #1;
      check({tag, ".release_ready"}, bus.req_ready, 0);
      check({tag, ".release_valid"}, bus.resp_valid, 0);
      @(negedge clk);
      ptr     = 0;
      err_exp = 1'b0;
   endtask

   // One full transaction: grant, EVAL, response held for 'stall' cycles, handshake.
   task automatic serve_one(input int stall, output int gid);
      int              g;
      logic [DW-1:0]   exp_op;
      logic [RW-1:0]   exp_res;
      logic [NREQ-1:0] exp_vec;
      drive_reqs();
      #1;
      g   = exp_grant();
      gid = g;
      if (g < 0) begin
         check("idle_no_grant", bus.req_ready, 0);
         check("idle_not_busy", bus.busy, 0);
         @(negedge clk);
         return;
      end
      exp_vec    = '0;
      exp_vec[g] = 1'b1;
      check("grant", bus.req_ready, exp_vec);
      exp_op  = opnd[g];
      exp_res = force_bad ? RW'(25) : RW'(exp_op % MOD);
      if (force_bad) err_exp = 1'b1;
      @(negedge clk);
      case (retire_mode)
         0:       active[g] = 1'b0;
         1:       opnd[g] = $urandom;
         default: begin
            active[g] = 1'($urandom_range(0, 1));
            opnd[g]   = $urandom;
         end
      endcase
      drive_reqs();
      check("eval_operand", bus.red_operand, exp_op);
      check("eval_no_resp", bus.resp_valid, 0);
      check("eval_busy", bus.busy, 1);
      #1;
      check("eval_no_ready", bus.req_ready, 0);
      @(negedge clk);
      last_id   = bus.resp_id;
      last_data = bus.resp_data;
      for (int s = 0; s <= stall; s++) begin
         check("resp_valid", bus.resp_valid, 1);
         check("resp_id", bus.resp_id, g);
         check("resp_data", bus.resp_data, exp_res);
         check("resp_err", bus.err, err_exp);
         check("resp_no_ready", bus.req_ready, 0);
         if (s == stall) bus.resp_ready = 1'b1;
         @(negedge clk);
      end
      bus.resp_ready = 1'b0;
      check("hs_valid_low", bus.resp_valid, 0);
      check("hs_not_busy", bus.busy, 0);
      ptr = (g + 1) % NREQ;
   endtask

   initial begin
      int g;
      rst            = 1'b1;
      force_bad      = 1'b0;
      bus.req_valid  = '0;
      bus.req_data   = '0;
      bus.resp_ready = 1'b0;
      retire_mode    = 0;
      for (int i = 0; i < NREQ; i++) begin
         active[i] = 1'b1;
         opnd[i]   = 32'(i + 5);
      end
      drive_reqs();
      repeat (3) @(negedge clk);
      #1;
      check_reset_outputs("rst_held");
      rst = 1'b0;
      #1;
      check("rst_release_ready", bus.req_ready, 0);
      @(negedge clk);
      ptr     = 0;
      err_exp = 1'b0;

      $display("[TB] T1 single requests");
      for (int i = 0; i < NREQ; i++) active[i] = 1'b0;
      active[0] = 1'b1;
      opnd[0]   = 32'd100;
      serve_one(0, g);
      check("t1a_id", last_id, 0);
      check("t1a_data", last_data, 16);
      active[0] = 1'b1;
      opnd[0]   = 32'hFFFF_FFFF;
      serve_one(0, g);
      check("t1b_id", last_id, 0);
      check("t1b_data", last_data, 3);

      $display("[TB] T2 all four requesters");
      do_reset("t2_rst");
      opnd[0] = 32'd21;
      opnd[1] = 32'd22;
      opnd[2] = 32'd43;
      opnd[3] = 32'hFFFF;
      for (int i = 0; i < NREQ; i++) active[i] = 1'b1;
      for (int n = 0; n < 4; n++) begin
         serve_one(0, g);
         check("t2_id", last_id, t2_id[n]);
         check("t2_data", last_data, t2_res[n]);
      end

      $display("[TB] T3 response back-pressure");
      active[1] = 1'b1;
      opnd[1]   = 32'd500;
      active[3] = 1'b1;
      opnd[3]   = 32'd7;
      serve_one(5, g);
      check("t3_id", last_id, 1);
      check("t3_data", last_data, 17);
      serve_one(0, g);
      check("t3_next_id", last_id, 3);
      check("t3_next_data", last_data, 7);

      $display("[TB] T4 two persistent requesters");
      retire_mode = 1;
      active[0]   = 1'b1;
      opnd[0]     = 32'd1000;
      active[2]   = 1'b1;
      opnd[2]     = 32'd2000;
      for (int n = 0; n < 6; n++) begin
         serve_one(0, g);
         check("t4_id", last_id, t4_id[n]);
      end

      $display("[TB] T5 reset during EVAL");
      retire_mode = 0;
      for (int i = 0; i < NREQ; i++) active[i] = 1'b0;
      active[1] = 1'b1;
      opnd[1]   = 32'd99;
      drive_reqs();
      #1;
      check("t5_grant", bus.req_ready, 4'b0010);
      @(negedge clk);
      check("t5_in_eval", bus.busy, 1);
      rst       = 1'b1;
      active[1] = 1'b0;
      drive_reqs();
      @(negedge clk);
      #1;
      check_reset_outputs("t5_rst");
      rst = 1'b0;
      @(negedge clk);
      ptr     = 0;
      err_exp = 1'b0;
      repeat (4) begin
         check("t5_no_resp", bus.resp_valid, 0);
         check("t5_idle", bus.busy, 0);
         @(negedge clk);
      end

      $display("[TB] T6 out-of-range residue");
      force_bad = 1'b1;
      active[2] = 1'b1;
      opnd[2]   = 32'd5;
      serve_one(0, g);
      check("t6_data", last_data, 25);
      check("t6_err", bus.err, 1);
      force_bad = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         active[i] = 1'b1;
         opnd[i]   = $urandom;
      end
      repeat (3) serve_one(0, g);
      check("t6_err_sticky", bus.err, 1);
      do_reset("t6_rst");

      $display("[TB] random phase");
      retire_mode = 2;
      for (int i = 0; i < NREQ; i++) active[i] = 1'b0;
      for (int n = 0; n < 40; n++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!active[i] && $urandom_range(0, 1) == 1) begin
               active[i] = 1'b1;
               opnd[i]   = $urandom;
            end else if (active[i] && $urandom_range(0, 7) == 0) begin
               active[i] = 1'b0;
            end
         end
         serve_one($urandom_range(0, 3), g);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
